// File: rtl/perf_pkg.sv
// Shared constants and state type for perf_reporter.
// Defining PERF_RETIRE_COUNT_EN adds the retired-instruction word ahead of the PC word.
package perf_pkg;

  localparam int unsigned IDX_W = 3;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_CYCLES   = 3'd0;
  localparam idx_t IDX_STALLS   = 3'd1;
  localparam idx_t IDX_FLUSHES  = 3'd2;
  localparam idx_t IDX_BRANCHES = 3'd3;
  localparam idx_t IDX_RETIRED  = 3'd4;

  localparam idx_t LAST_IDX_BASE   = 3'd4;
  localparam idx_t LAST_IDX_RETIRE = 3'd5;

`ifdef PERF_RETIRE_COUNT_EN
  localparam bit RETIRE_EN = 1'b1;
`else
  localparam bit RETIRE_EN = 1'b0;
`endif

  // The PC word always closes the report, right after the last counter word.
  localparam idx_t IDX_PC   = RETIRE_EN ? idx_t'(IDX_RETIRED + 3'd1) : IDX_RETIRED;
  localparam idx_t LAST_IDX = RETIRE_EN ? LAST_IDX_RETIRE : LAST_IDX_BASE;

  localparam int unsigned NUM_WORDS = int'(LAST_IDX) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/perf_counter.sv
// Single wrapping event counter: clear beats increment, increment needs both enable and inc.
module perf_counter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0] count_q, count_d;

  // NOTE: default assignment first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && inc) begin
      count_d = count_q + DATA_WIDTH'(1);
    end
  end

  // NOTE: non-blocking assignment so every flop samples its pre-edge inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/perf_reporter.sv
// Core performance counters with a snapshot-and-stream report interface (valid/ready).
// Build option: PERF_RETIRE_COUNT_EN adds a retired-instruction counter as report word 4.
module perf_reporter
  import perf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [1:0]              next_PC_sel,
  input  logic                    retire_valid,
  input  logic [ADDRESS_BITS-1:0] memwb_inst_PC,
  input  logic                    report,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [2:0]              out_index,
  output logic                    out_last,
  output logic                    busy
);

  state_e                state_q, state_d;
  idx_t                  idx_q, idx_d;
  logic                  count_en_q, count_en_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_WORDS];
  logic [DATA_WIDTH-1:0] live     [NUM_WORDS];
  logic [DATA_WIDTH-1:0] cycles_cnt, stalls_cnt, flushes_cnt, branches_cnt;
  logic [DATA_WIDTH-1:0] send_word;

  // Counting is armed by the first start and only a reset disarms it.
  always_comb count_en_d = count_en_q | start;

  perf_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cycles (
    .clock(clock), .reset(reset), .clear(start), .enable(count_en_q),
    .inc(1'b1), .count(cycles_cnt)
  );

  perf_counter #(.DATA_WIDTH(DATA_WIDTH)) u_stalls (
    .clock(clock), .reset(reset), .clear(start), .enable(count_en_q),
    .inc(stall), .count(stalls_cnt)
  );

  perf_counter #(.DATA_WIDTH(DATA_WIDTH)) u_flushes (
    .clock(clock), .reset(reset), .clear(start), .enable(count_en_q),
    .inc(flush), .count(flushes_cnt)
  );

  perf_counter #(.DATA_WIDTH(DATA_WIDTH)) u_branches (
    .clock(clock), .reset(reset), .clear(start), .enable(count_en_q),
    .inc(|next_PC_sel), .count(branches_cnt)
  );

`ifdef PERF_RETIRE_COUNT_EN
  logic [DATA_WIDTH-1:0] retired_cnt;

  perf_counter #(.DATA_WIDTH(DATA_WIDTH)) u_retired (
    .clock(clock), .reset(reset), .clear(start), .enable(count_en_q),
    .inc(retire_valid), .count(retired_cnt)
  );
`else
  logic retire_valid_unused;
  assign retire_valid_unused = retire_valid;
`endif

  // Counter outputs are the registered values, so a snapshot sees pre-increment/pre-clear state.
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) live[i] = '0;
    live[IDX_CYCLES]   = cycles_cnt;
    live[IDX_STALLS]   = stalls_cnt;
    live[IDX_FLUSHES]  = flushes_cnt;
    live[IDX_BRANCHES] = branches_cnt;
`ifdef PERF_RETIRE_COUNT_EN
    live[IDX_RETIRED]  = retired_cnt;
`endif
    live[IDX_PC]       = DATA_WIDTH'(memwb_inst_PC);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (report) begin
          shadow_d = live;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_en_q <= 1'b0;
      // NOTE: the shadow words are plain flops, cleared so a post-reset report never carries stale data.
      for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_en_q <= count_en_d;
      for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    send_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx_q == idx_t'(i)) send_word = shadow_q[i];
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_index = idx_q;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = out_valid ? send_word : '0;

endmodule

// File: tb/tb_perf_reporter.sv
// Directed bench for perf_reporter; a second 4-bit instance shares all inputs to exercise counter wrap.
module tb_perf_reporter;

`ifdef PERF_RETIRE_COUNT_EN
  localparam int N_WORDS = 6;
`else
  localparam int N_WORDS = 5;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start, stall, flush, retire_valid, report, out_ready;
  logic [1:0]  next_PC_sel;
  logic [19:0] memwb_inst_PC;

  logic        out_valid, out_last, busy;
  logic [31:0] out_data;
  logic [2:0]  out_index;

  logic        w_out_valid, w_out_last, w_busy;
  logic [3:0]  w_out_data;
  logic [2:0]  w_out_index;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got   [6];
  logic [3:0]  w_got [6];
  logic [31:0] exp_w [6];

  always #5 clock = ~clock;

  perf_reporter #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .flush(flush),
    .next_PC_sel(next_PC_sel), .retire_valid(retire_valid), .memwb_inst_PC(memwb_inst_PC),
    .report(report), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  perf_reporter #(.DATA_WIDTH(4), .ADDRESS_BITS(4)) dut_w (
    .clock(clock), .reset(reset), .start(start), .stall(stall), .flush(flush),
    .next_PC_sel(next_PC_sel), .retire_valid(retire_valid), .memwb_inst_PC(memwb_inst_PC[3:0]),
    .report(report), .out_ready(out_ready), .out_valid(w_out_valid), .out_data(w_out_data),
    .out_index(w_out_index), .out_last(w_out_last), .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic set_expected(input logic [31:0] c, input logic [31:0] s, input logic [31:0] f,
                              input logic [31:0] b, input logic [31:0] r, input logic [31:0] pc);
    exp_w[0] = c;
    exp_w[1] = s;
    exp_w[2] = f;
    exp_w[3] = b;
`ifdef PERF_RETIRE_COUNT_EN
    exp_w[4] = r;
    exp_w[5] = pc;
`else
    exp_w[4] = pc;
    exp_w[5] = r;
`endif
  endtask

  // Called right after report is sampled; streams one word per cycle with out_ready=1.
  task automatic read_report(input string tag);
    for (int i = 0; i < N_WORDS; i++) begin
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " index"}, 32'(out_index), 32'(i));
      check({tag, " last"},  32'(out_last),  32'(i == N_WORDS - 1));
      got[i]   = out_data;
      w_got[i] = w_out_data;
      cyc(1);
    end
    check({tag, " done"}, 32'(out_valid), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_words(input string tag);
    for (int i = 0; i < N_WORDS; i++) begin
      check($sformatf("%s word%0d", tag, i), got[i], exp_w[i]);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; retire_valid = 1'b0;
    report = 1'b0; out_ready = 1'b1; next_PC_sel = 2'b00; memwb_inst_PC = '0;
    #2;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst busy",  32'(busy),      32'd0);
    check("rst last",  32'(out_last),  32'd0);
    check("rst data",  out_data,       32'd0);
    check("rst index", 32'(out_index), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc(1);

    // Scenario 1: basic report, 10 idle cycles after start
    start_pulse();
    cyc(10);
    memwb_inst_PC = 20'hABCDE;
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    set_expected(32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'h000ABCDE);
    read_report("s1");
    compare_words("s1");

    // Scenario 2: event counts
    start_pulse();
    stall = 1'b1; retire_valid = 1'b1;
    cyc(3);
    stall = 1'b0; flush = 1'b1;
    cyc(2);
    flush = 1'b0; retire_valid = 1'b0; next_PC_sel = 2'b01;
    cyc(4);
    next_PC_sel = 2'b00;
    memwb_inst_PC = 20'h00444;
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    set_expected(32'd9, 32'd3, 32'd2, 32'd4, 32'd5, 32'h00000444);
    read_report("s2");
    compare_words("s2");

    // Scenario 3: backpressure on word 1, plus an ignored report pulse during SEND
    start_pulse();
    stall = 1'b1;
    cyc(2);
    stall = 1'b0;
    cyc(2);
    memwb_inst_PC = 20'h12345;
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    set_expected(32'd4, 32'd2, 32'd0, 32'd0, 32'd0, 32'h00012345);
    check("s3 w0 index", 32'(out_index), 32'd0);
    check("s3 w0 data",  out_data,       exp_w[0]);
    cyc(1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("s3 hold valid", 32'(out_valid), 32'd1);
      check("s3 hold index", 32'(out_index), 32'd1);
      check("s3 hold data",  out_data,       exp_w[1]);
      report = (k == 1);
      cyc(1);
    end
    report = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < N_WORDS; i++) begin
      check("s3 index", 32'(out_index), 32'(i));
      check("s3 data",  out_data,       exp_w[i]);
      check("s3 last",  32'(out_last),  32'(i == N_WORDS - 1));
      cyc(1);
    end
    for (int k = 0; k < 3; k++) begin
      check("s3 no extra word", 32'(out_valid), 32'd0);
      cyc(1);
    end

    // Scenario 4: wrap, 4-bit instance sees 16 increments -> 0
    start_pulse();
    cyc(16);
    memwb_inst_PC = 20'h7777B;
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    check("s4 narrow valid", 32'(w_out_valid), 32'd1);
    read_report("s4");
    check("s4 wide cycles",   got[0],          32'd16);
    check("s4 narrow cycles", 32'(w_got[0]),   32'd0);
    check("s4 narrow stalls", 32'(w_got[1]),   32'd0);
    check("s4 narrow pc",     32'(w_got[N_WORDS-1]), 32'hB);

    // Scenario 5: start and report in the same cycle
    start_pulse();
    stall = 1'b1;
    cyc(7);
    stall = 1'b0;
    start = 1'b1;
    report = 1'b1;
    memwb_inst_PC = 20'h00055;
    cyc(1);
    start = 1'b0;
    report = 1'b0;
    set_expected(32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'h00000055);
    read_report("s5a");
    compare_words("s5a");
    stall = 1'b1;
    cyc(2);
    stall = 1'b0;
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    set_expected(32'(2 + N_WORDS), 32'd2, 32'd0, 32'd0, 32'd0, 32'h00000055);
    read_report("s5b");
    compare_words("s5b");

    // Scenario 6: reset during word 2
    start_pulse();
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    check("s6 w0 data", out_data, 32'd0);
    cyc(1);
    check("s6 w1 index", 32'(out_index), 32'd1);
    cyc(1);
    check("s6 w2 index", 32'(out_index), 32'd2);
    reset = 1'b0;
    #1;
    check("s6 rst valid",  32'(out_valid),   32'd0);
    check("s6 rst busy",   32'(busy),        32'd0);
    check("s6 rst index",  32'(out_index),   32'd0);
    check("s6 rst data",   out_data,         32'd0);
    check("s6 rst last",   32'(out_last),    32'd0);
    check("s6 rst nvalid", 32'(w_out_valid), 32'd0);
    cyc(1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("s6 post valid", 32'(out_valid), 32'd0);
      cyc(1);
    end
    report = 1'b1;
    cyc(1);
    report = 1'b0;
    set_expected(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h00000055);
    read_report("s6");
    compare_words("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
